// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file with a per-register pending-write scoreboard.
// Combinational reads with optional writeback bypass; hazard stalls decode when a source or destination can't be served.
module reg_file_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_value,
  input  logic                     flush,
  output logic                     hazard,
  output logic                     issue_ack,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX  = '1;
  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [PEND_W-1:0] cnt_q  [NUM_REGS];
  logic [PEND_W-1:0] cnt_d  [NUM_REGS];
  logic [NUM_RD-1:0] src_haz;
  logic              dst_haz;

  // Read ports and per-port source hazards.
  always_comb begin : read_ports
    logic [ADDR_W-1:0] addr;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    rd_data = '0;
    src_haz = '0;
    addr    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr                        = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = regs_q[addr];
      src_haz[i]                  = rd_en[i] && (cnt_q[addr] != '0);
      if (BYPASS == 1 && wb_en && wb_dest == addr) begin
        rd_data[i*DATA_W +: DATA_W] = wb_value;
        // The writeback landing now is the last one outstanding, so the forwarded value is final.
        if (cnt_q[addr] == CNT_ONE) src_haz[i] = 1'b0;
      end
    end
  end

  always_comb begin : hazard_logic
    dst_haz   = issue_en && (cnt_q[issue_dest] == CNT_MAX);
    hazard    = ((|src_haz) || dst_haz) && !flush;
    issue_ack = issue_en && !hazard;
  end

  // Next-state for data and pending counters; a writeback always lands, flush only clears counters.
  always_comb begin : next_state
    logic inc;
    logic dec;
    inc      = 1'b0;
    dec      = 1'b0;
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = issue_ack && (issue_dest == ADDR_W'(r));
      dec = wb_en && (wb_dest == ADDR_W'(r)) && (cnt_q[r] != '0);

      cnt_d[r] = cnt_q[r];
      if (flush)            cnt_d[r] = '0;
      else if (inc && !dec) cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_ONE;

      regs_d[r] = regs_q[r];
      if (wb_en && (wb_dest == ADDR_W'(r))) regs_d[r] = wb_value;

      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data array is reset too, since reads must return 0 straight after reset;
      // that rules out mapping it onto a RAM without a reset.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values, independent of block order.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: a table of per-cycle vectors plus hand sequences
// for the BYPASS=0 variant and asynchronous reset.
module tb_reg_file_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_en;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_dest;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_dest;
  logic [DATA_W-1:0]        wb_value;
  logic                     flush;

  logic [NUM_RD-1:0][DATA_W-1:0] rd_data,  rd_data_nb;
  logic                          hazard,   hazard_nb;
  logic                          issue_ack, issue_ack_nb;
  logic [15:0]                   busy_vec, busy_vec_nb;

  reg_file_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .issue_en(issue_en), .issue_dest(issue_dest), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .flush(flush), .hazard(hazard), .issue_ack(issue_ack),
    .busy_vec(busy_vec)
  );

  reg_file_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_nb),
    .issue_en(issue_en), .issue_dest(issue_dest), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .flush(flush), .hazard(hazard_nb), .issue_ack(issue_ack_nb),
    .busy_vec(busy_vec_nb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NUM_RD-1:0][ADDR_W-1:0] ra;
    logic [NUM_RD-1:0]             re;
    logic                          ie;
    logic [ADDR_W-1:0]             id;
    logic                          we;
    logic [ADDR_W-1:0]             wd;
    logic [DATA_W-1:0]             wv;
    logic                          fl;
    logic                          e_haz;
    logic                          e_ack;
    logic [15:0]                   e_busy;
    logic [NUM_RD-1:0][DATA_W-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(
    input int a0, input int a1, input int a2, input logic [2:0] re,
    input logic ie, input int id, input logic we, input int wd, input logic [31:0] wv,
    input logic fl, input logic e_haz, input logic e_ack, input logic [15:0] e_busy,
    input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    vec_t v;
    v.ra[0] = ADDR_W'(a0); v.ra[1] = ADDR_W'(a1); v.ra[2] = ADDR_W'(a2);
    v.re = re; v.ie = ie; v.id = ADDR_W'(id);
    v.we = we; v.wd = ADDR_W'(wd); v.wv = wv; v.fl = fl;
    v.e_haz = e_haz; v.e_ack = e_ack; v.e_busy = e_busy;
    v.e_rd[0] = r0; v.e_rd[1] = r1; v.e_rd[2] = r2;
    return v;
  endfunction

  task automatic idle_inputs();
    rd_addr = '0; rd_en = '0; issue_en = 1'b0; issue_dest = '0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0; flush = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //        a0 a1 a2 re      ie id we wd wv            fl  haz ack busy     rd0           rd1           rd2
    tbl.push_back(mk(0, 5,15, 3'b000, 0, 0, 0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 1, 3, 0, 0, 32'h0,        0, 0, 1, 16'h0000, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(3, 5,15, 3'b001, 1, 8, 0, 0, 32'h0,        0, 1, 0, 16'h0008, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(3, 5,15, 3'b001, 0, 0, 1, 3, 32'h12,       0, 0, 0, 16'h0008, 32'h12,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(3, 5,15, 3'b001, 1, 7, 0, 0, 32'h0,        0, 0, 1, 16'h0000, 32'h12,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 1, 7, 0, 0, 32'h0,        0, 0, 1, 16'h0080, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 1, 7, 0, 0, 32'h0,        0, 0, 1, 16'h0080, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 1, 7, 0, 0, 32'h0,        0, 1, 0, 16'h0080, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 5,15, 3'b000, 1, 7, 0, 0, 32'h0,        0, 1, 0, 16'h0080, 32'h0,        32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(7, 5,15, 3'b000, 0, 0, 1, 7, 32'h77,       0, 0, 0, 16'h0080, 32'h77,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(7, 5,15, 3'b000, 0, 0, 1, 7, 32'h78,       0, 0, 0, 16'h0080, 32'h78,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(7, 5,15, 3'b001, 0, 0, 1, 7, 32'h79,       0, 0, 0, 16'h0080, 32'h79,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(7, 5,15, 3'b001, 0, 0, 0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h79,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(7, 5,15, 3'b000, 1, 4, 0, 0, 32'h0,        0, 0, 1, 16'h0000, 32'h79,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(4, 5,15, 3'b000, 1, 4, 1, 4, 32'h44,       0, 0, 1, 16'h0010, 32'h44,       32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(4, 9,15, 3'b000, 0, 0, 1, 9, 32'h99,       0, 0, 0, 16'h0010, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(4, 9,15, 3'b001, 0, 0, 0, 0, 32'h0,        0, 1, 0, 16'h0010, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(4, 9,15, 3'b000, 1, 5, 0, 0, 32'h0,        0, 0, 1, 16'h0010, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(4, 9,15, 3'b000, 1, 6, 0, 0, 32'h0,        0, 0, 1, 16'h0030, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(4, 9,15, 3'b000, 1, 7, 0, 0, 32'h0,        0, 0, 1, 16'h0070, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(4, 9,15, 3'b001, 1, 2, 1, 6, 32'h66,       1, 0, 1, 16'h00F0, 32'h44,       32'h99,       32'h0));
    tbl.push_back(mk(6, 2, 9, 3'b111, 0, 0, 0, 0, 32'h0,        0, 0, 0, 16'h0000, 32'h66,       32'h0,        32'h99));

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      rd_addr = tbl[i].ra; rd_en = tbl[i].re;
      issue_en = tbl[i].ie; issue_dest = tbl[i].id;
      wb_en = tbl[i].we; wb_dest = tbl[i].wd; wb_value = tbl[i].wv; flush = tbl[i].fl;
      #1;
      check($sformatf("v%0d hazard", i),    64'(hazard),     64'(tbl[i].e_haz));
      check($sformatf("v%0d issue_ack", i), 64'(issue_ack),  64'(tbl[i].e_ack));
      check($sformatf("v%0d busy_vec", i),  64'(busy_vec),   64'(tbl[i].e_busy));
      for (int p = 0; p < NUM_RD; p++)
        check($sformatf("v%0d rd_data[%0d]", i, p), 64'(rd_data[p]), 64'(tbl[i].e_rd[p]));
    end

    // Asynchronous reset mid-cycle with a pending counter and nonzero data.
    @(negedge clk);
    idle_inputs();
    issue_en = 1'b1; issue_dest = 4'd1;
    @(negedge clk);
    idle_inputs();
    rd_addr[0] = 4'd1; rd_addr[1] = 4'd5; rd_addr[2] = 4'd6; rd_en = 3'b111;
    #1;
    check("pre_reset busy_vec", 64'(busy_vec), 64'h0002);
    check("pre_reset rd_data[1]", 64'(rd_data[1]), 64'hDEADBEEF);
    check("pre_reset hazard", 64'(hazard), 64'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset busy_vec", 64'(busy_vec), 64'h0);
    check("async_reset hazard", 64'(hazard), 64'h0);
    for (int p = 0; p < NUM_RD; p++)
      check($sformatf("async_reset rd_data[%0d]", p), 64'(rd_data[p]), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // BYPASS=0: the same-cycle writeback neither forwards nor clears the hazard.
    @(negedge clk);
    idle_inputs();
    issue_en = 1'b1; issue_dest = 4'd3;
    @(negedge clk);
    idle_inputs();
    rd_addr[0] = 4'd3; rd_en = 3'b001;
    #1;
    check("nb hazard pending", 64'(hazard_nb), 64'h1);
    check("nb issue_ack pending", 64'(issue_ack_nb), 64'h0);
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h12;
    #1;
    check("nb hazard wb_cycle", 64'(hazard_nb), 64'h1);
    check("nb rd_data wb_cycle", 64'(rd_data_nb[0]), 64'h0);
    check("byp hazard wb_cycle", 64'(hazard), 64'h0);
    check("byp rd_data wb_cycle", 64'(rd_data[0]), 64'h12);
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    check("nb hazard after_wb", 64'(hazard_nb), 64'h0);
    check("nb rd_data after_wb", 64'(rd_data_nb[0]), 64'h12);
    check("nb busy_vec after_wb", 64'(busy_vec_nb), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised register file with a built-in per-register pending-write scoreboard, for the decode stage.
- Supports NUM_RD combinational read ports, one writeback port and optional writeback-to-read bypass.
- Tracks outstanding destination writes and raises hazard when an enabled source or the issuing destination cannot be served.
- Successor to the fixed 16x32, two-read-port register file; decode uses hazard directly instead of an external hazard unit.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W
- NUM_RD, 3, number of read ports
- PEND_W, 2, width of each pending-write counter; max outstanding writes per register = 2**PEND_W-1
- BYPASS, 1, 1 = a same-cycle writeback is forwarded to the reads and clears the hazard; 0 = no forwarding

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_en  input  NUM_RD  port i source is used (hazard check enable)
- rd_data  output  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
- issue_en  input  1  decode wants to issue an instruction that writes issue_dest
- issue_dest  input  ADDR_W  destination of the issuing instruction
- wb_en  input  1  writeback valid
- wb_dest  input  ADDR_W  writeback register
- wb_value  input  DATA_W  writeback data
- flush  input  1  discard all in-flight writes from the scoreboard
- hazard  output  1  stall decode; issue is blocked this cycle
- issue_ack  output  1  issue accepted = issue_en & ~hazard
- busy_vec  output  NUM_REGS  bit r = pending counter r nonzero (registered view)

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all counters = 0, busy_vec = 0. Combinational outputs follow: hazard = 0, issue_ack = issue_en, rd_data = 0 unless a bypass applies.
- Write:
  - On a rising edge with wb_en=1: reg[wb_dest] <= wb_value.
  - The write always happens, whatever the counter value, flush or hazard.
- Read (combinational, zero latency):
  - rd_data[i] = reg[rd_addr[i]].
  - If BYPASS=1 and wb_en and wb_dest==rd_addr[i]: rd_data[i] = wb_value.
  - rd_en does not gate rd_data.
- Per-port source hazard:
  - src_haz[i] = rd_en[i] & (cnt[rd_addr[i]] != 0).
  - Exception when BYPASS=1: no hazard if cnt==1 & wb_en & wb_dest==rd_addr[i].
- Destination hazard: dst_haz = issue_en & (cnt[issue_dest] == max), where max = 2**PEND_W-1.
- hazard = OR of src_haz | dst_haz. hazard is suppressed (0) when flush=1.
- Counter update, per register r, at each rising edge:
  - inc = issue_ack & issue_dest==r.
  - dec = wb_en & wb_dest==r & cnt[r]!=0. Underflow is ignored: a writeback to a counter at 0 leaves it at 0.
  - inc & dec: unchanged. inc only: +1. dec only: -1.
  - flush=1 overrides all of the above: every counter <= 0. The issue is not recorded, even though issue_ack may be 1; decode is responsible for discarding the issued instruction on flush.
- busy_vec = (cnt != 0) per register, derived from registers only.
- An issue and a writeback to the same register in the same cycle, with cnt=1: the counter stays 1 (old write done, new write pending).
- Reset mid-operation: all pending state is lost; data written before reset is cleared to 0.

Test Plan:
- Reset, then read ports {0,5,15} -> rd_data all 0, hazard=0, busy_vec=0. Then wb_en wb_dest=5 wb_value=0xDEADBEEF; next cycle port1 reads 0xDEADBEEF.
- Issue dest=3, then next cycle rd_en[0]=1 rd_addr[0]=3 with no writeback -> hazard=1, issue_ack=0. Then wb_dest=3 wb_value=0x12 in the same cycle:
  - BYPASS=1 -> hazard=0, rd_data[0]=0x12.
  - BYPASS=0 -> hazard=1 for that cycle, 0 the next.
- Issue dest=7 three times (PEND_W=2) -> busy_vec[7]=1, cnt=3. A fourth issue_en to 7 -> hazard=1, issue_ack=0, counter stays 3. Three writebacks to 7 -> busy_vec[7]=0.
- With cnt[4]=1, issue dest=4 and wb_dest=4 in the same cycle -> cnt[4]=1 afterwards, reg[4]=wb_value. A writeback to r9 with cnt[9]=0 -> counter 0, data written.
- busy_vec=0x00F0, assert flush with issue_en dest=2 and wb to r6 -> next cycle busy_vec=0, reg[6] updated, hazard=0 during flush.
- Drop rst asynchronously mid-cycle with pending counters and nonzero data -> busy_vec=0 and reads return 0 immediately, without waiting for a clock edge.
